// File: rtl/wind_pkg.sv
// wind_pkg: shared constants, FSM state type and saturation helper for the wind back end
package wind_pkg;
    localparam int DEG180      = 184320;
    localparam int DEG360      = 368640;
    localparam int ANGLE_W_DEF = 19;
    localparam int SPEED_W_DEF = 16;
    typedef enum logic [2:0] {S_IDLE, S_DIFF, S_ACC, S_SCALE, S_OUT} state_t;
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return x > hi ? hi : (x < lo ? lo : x);
    endfunction
endpackage

// File: rtl/phasewrap.sv
// phasewrap: combinational A-B phase difference wrapped into [-180, +180) degrees (Q10)
// Ports: i_a, i_b signed W-bit angles; o_d signed W-bit wrapped difference
module phasewrap import wind_pkg::*; #(
    parameter int W = ANGLE_W_DEF
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_d
);
    logic signed [W:0] w_raw, w_wrap;
    assign w_raw  = (W+1)'(i_a) - (W+1)'(i_b);
    assign w_wrap = w_raw >= DEG180 ? w_raw - (W+1)'(DEG360) :
                    w_raw < -DEG180 ? w_raw + (W+1)'(DEG360) : w_raw;
    assign o_d    = W'(w_wrap);
endmodule

// File: rtl/wind_multiaxis.sv
// wind_multiaxis: time-multiplexed multi-axis phase-difference averager and speed scaler
// Ports: i_clock, i_reset (async high), i_enable, i_sample strobe, i_angA/i_angB packed
// per-axis angles, i_meanlen window exponent; o_speed packed speeds, o_ready update pulse,
// o_busy (FSM not idle), o_overrun (sticky dropped-sample flag)
module wind_multiaxis import wind_pkg::*; #(
    parameter int                 NAXES       = 2,
    parameter int                 ANGLE_W     = ANGLE_W_DEF,
    parameter int                 SPEED_W     = SPEED_W_DEF,
    parameter int                 MAXLOG2     = 8,
    parameter logic signed [15:0] SCALE       = 16'sd1024,
    parameter int                 SCALE_SHIFT = 10
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_sample,
    input  logic [NAXES*ANGLE_W-1:0]   i_angA,
    input  logic [NAXES*ANGLE_W-1:0]   i_angB,
    input  logic [3:0]                 i_meanlen,
    output logic [NAXES*SPEED_W-1:0]   o_speed,
    output logic                       o_ready,
    output logic                       o_busy,
    output logic                       o_overrun
);
    localparam int IW  = NAXES > 1 ? $clog2(NAXES) : 1;
    localparam int ACW = ANGLE_W + MAXLOG2;
    localparam int PW  = ACW + 16;
    localparam int CW  = MAXLOG2 + 1;

    state_t                      r_state;
    logic [IW-1:0]               r_i;
    logic [CW-1:0]               r_cnt;
    logic [3:0]                  r_len;
    logic [NAXES*ANGLE_W-1:0]    r_a, r_b;
    logic signed [ANGLE_W-1:0]   r_d;
    logic signed [ACW-1:0]       r_acc [NAXES];
    logic signed [PW-1:0]        r_prod;
    logic [NAXES*SPEED_W-1:0]    r_speed;
    logic                        r_ready, r_overrun;

    logic signed [ANGLE_W-1:0]   w_d;
    logic signed [ACW-1:0]       w_mean;
    logic                        w_last, w_win_end, w_accept, w_new_win;
    logic [3:0]                  w_len;

    phasewrap #(.W(ANGLE_W)) u_wrap (
        .i_a (r_a[int'(r_i)*ANGLE_W +: ANGLE_W]),
        .i_b (r_b[int'(r_i)*ANGLE_W +: ANGLE_W]),
        .o_d (w_d)
    );

    assign w_last    = r_i == IW'(NAXES - 1);
    assign w_win_end = r_cnt == (CW'(1) << r_len) - CW'(1);
    assign w_mean    = r_acc[r_i] >>> r_len;
    assign w_len     = i_meanlen > MAXLOG2 ? 4'(MAXLOG2) : i_meanlen;
    // A new sample may be taken on the very edge the FSM returns to IDLE.
    assign w_accept  = i_sample & i_enable & (r_state == S_IDLE |
                       (r_state == S_ACC & w_last & !w_win_end) | (r_state == S_OUT & w_last));
    // Window exponent is only relatched when the window counter is (or becomes) zero.
    assign w_new_win = r_state == S_OUT | (r_state == S_IDLE & r_cnt == '0);

    assign o_speed   = r_speed;
    assign o_ready   = r_ready;
    assign o_busy    = r_state != S_IDLE;
    assign o_overrun = r_overrun;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_prod    <= '0;
            r_speed   <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            for (int n = 0; n < NAXES; n++) r_acc[n] <= '0;
        end else begin
            r_ready <= 1'b0;
            if (i_sample & i_enable & o_busy & !w_accept) r_overrun <= 1'b1;
            case (r_state)
                S_DIFF: begin
                    r_d     <= w_d;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_acc[r_i] <= r_acc[r_i] + ACW'(r_d);
                    if (!w_last) begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_DIFF;
                    end else if (w_win_end) begin
                        r_i     <= '0;
                        r_state <= S_SCALE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_SCALE: begin
                    r_prod  <= PW'(w_mean) * PW'(SCALE);
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_speed[int'(r_i)*SPEED_W +: SPEED_W] <=
                        SPEED_W'(saturate(64'(r_prod >>> SCALE_SHIFT), SPEED_W));
                    r_acc[r_i] <= '0;
                    if (!w_last) begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_SCALE;
                    end else begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase
            if (w_accept) begin
                r_a     <= i_angA;
                r_b     <= i_angB;
                r_i     <= '0;
                r_state <= S_DIFF;
                if (w_new_win) r_len <= w_len;
            end
        end
    end
endmodule

// File: tb/tb_wind_multiaxis.sv
// tb_wind_multiaxis: scoreboard bench for wind_multiaxis with NAXES=2 and identity gain
module tb_wind_multiaxis;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b1, sample = 1'b0;
    logic [37:0] angA = '0, angB = '0;
    logic [3:0]  meanlen = '0;
    logic [31:0] speed;
    logic        ready, busy, overrun;
    int          errors = 0, checks = 0, cyc = 0, k0 = 0;
    logic [31:0] q[$];

    wind_multiaxis #(.NAXES(2)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_sample(sample),
        .i_angA(angA), .i_angB(angB), .i_meanlen(meanlen),
        .o_speed(speed), .o_ready(ready), .o_busy(busy), .o_overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no update at cycle %0d", cyc);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                chk("speed0", int'($signed(speed[15:0])), int'($signed(e[15:0])));
                chk("speed1", int'($signed(speed[31:16])), int'($signed(e[31:16])));
            end
        end
    end

    task automatic expect_speed(int e0, int e1);
        q.push_back({16'(e1), 16'(e0)});
    endtask

    task automatic drive(int a0, int b0, int a1, int b1);
        angA = {19'(a1), 19'(a0)};
        angB = {19'(b1), 19'(b0)};
    endtask

    task automatic send(int a0, int b0, int a1, int b1);
        @(negedge clk);
        drive(a0, b0, a1, b1);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        k0 = cyc;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 64 && busy; n++) @(negedge clk);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 64 cycles");
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_speed", int'(speed), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // Basic diff plus wrapped axis, with latency check
        meanlen = 4'd0;
        expect_speed(10240, 20480);
        send(30720, 20480, -174080, 174080);
        chk("busy_after_accept", int'(busy), 1);
        for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
        chk("ready_latency", cyc - k0, 8);
        wait_idle();

        // Positive wrap and exact +180 boundary
        expect_speed(-20480, -32768);
        send(174080, -174080, 92160, -92160);
        wait_idle();

        // Saturation both directions
        expect_speed(32767, -32768);
        send(51200, -51200, -51200, 51200);
        wait_idle();

        // Four-sample window
        meanlen = 4'd2;
        for (int s = 1; s <= 4; s++) begin
            if (s == 4) expect_speed(2560, -2560);
            send(1024 * s, 0, 0, 1024 * s);
            wait_idle();
        end

        // meanlen above MAXLOG2 clamps to a 256-sample window
        meanlen = 4'd15;
        for (int s = 1; s <= 256; s++) begin
            if (s == 256) expect_speed(1024, -2048);
            send(1024, 0, 0, 2048);
            wait_idle();
        end
        meanlen = 4'd0;

        // Samples ignored while disabled
        enable = 1'b0;
        send(4096, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("disabled_busy", int'(busy), 0);
        chk("disabled_overrun", int'(overrun), 0);
        enable = 1'b1;

        // Overrun: back-to-back strobe is dropped and absent from the mean
        meanlen = 4'd1;
        @(negedge clk);
        drive(1024, 0, 0, 0);
        sample = 1'b1;
        @(negedge clk);
        drive(9999, 0, 5000, 0);
        @(negedge clk);
        sample = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        wait_idle();
        expect_speed(2048, 0);
        send(3072, 0, 0, 0);
        wait_idle();
        chk("overrun_sticky", int'(overrun), 1);

        // Reset mid-window discards partial sums
        meanlen = 4'd2;
        send(50000, 0, 50000, 0);
        wait_idle();
        send(50000, 0, 50000, 0);
        wait_idle();
        send(50000, 0, 50000, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_speed", int'(speed), 0);
        chk("mid_rst_ready", int'(ready), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            if (s == 4) expect_speed(2560, -2560);
            send(1024 * s, 0, 0, 1024 * s);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("pending_expected", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
